// File: rtl/pld_pkg.sv
// Shared types and config-field layout for the programmable macrocell array.
package pld_pkg;

  typedef enum logic [1:0] {
    MODE_COMB   = 2'b00,
    MODE_DREG   = 2'b01,
    MODE_TREG   = 2'b10,
    MODE_STICKY = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    CFG_IDLE   = 2'b00,
    CFG_SHIFT  = 2'b01,
    CFG_COMMIT = 2'b10
  } cfg_state_e;

  // Per-cell field layout, LSB first: inv, en, mode, oe.
  localparam int INV_LSB = 0;

  function automatic int cfg_width(input int n_in);
    return 2 * n_in + 3;
  endfunction

  function automatic int en_lsb(input int n_in);
    return n_in;
  endfunction

  function automatic int mode_lsb(input int n_in);
    return 2 * n_in;
  endfunction

  function automatic int oe_bit(input int n_in);
    return 2 * n_in + 2;
  endfunction

endpackage

// File: rtl/pld_macrocell.sv
// One macrocell: inverted/enabled OR term, optional register, output mux.
module pld_macrocell
  import pld_pkg::*;
#(
  parameter int N_IN = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            commit,
  input  logic [N_IN-1:0] in,
  input  logic [2*N_IN+2:0] cfg,
  output logic            out,
  output logic            oe
);

  logic [N_IN-1:0] inv;
  logic [N_IN-1:0] en;
  mode_e           mode;
  logic            term;
  logic            q;

  assign inv  = cfg[INV_LSB +: N_IN];
  assign en   = cfg[en_lsb(N_IN) +: N_IN];
  assign mode = mode_e'(cfg[mode_lsb(N_IN) +: 2]);
  assign oe   = cfg[oe_bit(N_IN)];
  assign term = |(en & (in ^ inv));

  // q keeps following term in COMB mode so a later mode switch starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (commit) begin
      q <= 1'b0;
    end else if (clr) begin
      q <= 1'b0;
    end else begin
      case (mode)
        MODE_COMB:   q <= term;
        MODE_DREG:   q <= term;
        MODE_TREG:   q <= q ^ term;
        MODE_STICKY: q <= q | term;
        default:     q <= term;
      endcase
    end
  end

  assign out = (mode == MODE_COMB) ? term : q;

endmodule

// File: rtl/pld_macrocell_array.sv
// Macrocell array with a serial config chain loaded into a shadow register
// and committed to the active config in one cycle.
module pld_macrocell_array
  import pld_pkg::*;
#(
  parameter int N_IN   = 5,
  parameter int N_CELL = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CELL*N_IN-1:0]   in,
  output logic [N_CELL-1:0]        out,
  output logic [N_CELL-1:0]        oe,
  input  logic                     clr,
  input  logic                     cfg_start,
  input  logic                     cfg_valid,
  input  logic                     cfg_din,
  output logic                     cfg_busy,
  output logic                     cfg_done
);

  localparam int CFG_W   = 2 * N_IN + 3;
  localparam int CHAIN_W = N_CELL * CFG_W;
  localparam int CNT_W   = $clog2(CHAIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_W - 1);

  cfg_state_e         state;
  logic [CNT_W-1:0]   count;
  logic [CHAIN_W-1:0] shadow;
  logic [CHAIN_W-1:0] active;
  logic               commit;

  assign commit   = (state == CFG_COMMIT);
  assign cfg_busy = (state != CFG_IDLE);

  // A restart in SHIFT only rewinds the counter; stale shadow bits get
  // shifted out by the fresh stream before any commit can happen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CFG_IDLE;
      count    <= '0;
      shadow   <= '0;
      active   <= '0;
      cfg_done <= 1'b0;
    end else begin
      cfg_done <= commit;
      case (state)
        CFG_IDLE: begin
          if (cfg_start) begin
            state <= CFG_SHIFT;
            count <= '0;
          end
        end
        CFG_SHIFT: begin
          if (cfg_start) begin
            count <= '0;
          end else if (cfg_valid) begin
            shadow <= {shadow[CHAIN_W-2:0], cfg_din};
            count  <= count + 1'b1;
            if (count == LAST_BIT) begin
              state <= CFG_COMMIT;
            end
          end
        end
        CFG_COMMIT: begin
          active <= shadow;
          state  <= CFG_IDLE;
        end
        default: state <= CFG_IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < N_CELL; c++) begin : g_cell
    pld_macrocell #(
      .N_IN (N_IN)
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .commit (commit),
      .in     (in[c*N_IN +: N_IN]),
      .cfg    (active[c*CFG_W +: CFG_W]),
      .out    (out[c]),
      .oe     (oe[c])
    );
  end

endmodule
